// File: rtl/apb_master.sv
// APB4 requester driven by a core datapath: one transfer at a time, with size-aware
// lane steering, misalignment fault, wait-state timeout and a sticky error status.
module apb_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        write_in,
  input  logic [1:0]  size_in,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [15:0] LP_TLAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_FAULT} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_pwdata, r_rdata;
  logic [3:0]  r_pstrb;
  logic        r_write, r_done, r_err;
  logic [1:0]  r_code;
  logic [15:0] r_cnt;

  logic        w_misalign, w_tmo;
  logic [31:0] w_wfmt;
  logic [3:0]  w_base, w_strb;

  assign w_misalign = ((size_in == 2'b01) && addr_in[0]) ||
                      (size_in[1] && (addr_in[1:0] != 2'b00));
  assign w_tmo      = (r_cnt == LP_TLAST);

  always_comb begin
    w_wfmt = wdata_in;
    w_base = 4'b1111;
    case (size_in)
      2'b00:   begin w_wfmt = {4{wdata_in[7:0]}};  w_base = 4'b0001; end
      2'b01:   begin w_wfmt = {2{wdata_in[15:0]}}; w_base = 4'b0011; end
      default: begin w_wfmt = wdata_in;            w_base = 4'b1111; end
    endcase
    w_strb = w_base << addr_in[1:0];
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req) w_next = w_misalign ? S_FAULT : S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (pready || w_tmo) w_next = S_IDLE;
      S_FAULT:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // bus-phase outputs
  always_comb begin
    psel    = (r_state == S_SETUP) || (r_state == S_ACCESS);
    penable = (r_state == S_ACCESS);
    busy    = (r_state != S_IDLE);
  end

  // request latch, wait counter and completion status
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
      r_write  <= 1'b0;
      r_rdata  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_code   <= 2'b00;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (req) begin
          r_addr   <= addr_in;
          r_write  <= write_in;
          r_pwdata <= w_wfmt;
          r_pstrb  <= write_in ? w_strb : 4'b0000;
          r_cnt    <= '0;
        end
        S_ACCESS: begin
          if (pready) begin
            r_done <= 1'b1;
            r_err  <= pslverr;
            r_code <= pslverr ? 2'b01 : 2'b00;
            // read data is captured even on slverr so the core can inspect it
            if (!r_write) r_rdata <= prdata >> {r_addr[1:0], 3'b000};
          end else if (w_tmo) begin
            r_done <= 1'b1;
            r_err  <= 1'b1;
            r_code <= 2'b10;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_FAULT: begin
          r_done <= 1'b1;
          r_err  <= 1'b1;
          r_code <= 2'b11;
        end
        default: ;
      endcase
    end
  end

  assign paddr    = r_addr;
  assign pwrite   = r_write;
  assign pwdata   = r_pwdata;
  assign pstrb    = r_pstrb;
  assign done     = r_done;
  assign rdata    = r_rdata;
  assign err      = r_err;
  assign err_code = r_code;

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum ACCESS-phase cycles before abort, range 2..65535.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port req, input, 1: transfer request from core datapath, sampled only in IDLE.
REQ-005 SHALL have port addr_in, input, 32: byte address (datapath APB_paddr_val).
REQ-006 SHALL have port wdata_in, input, 32: store data, low-aligned (datapath APB_pdata_val).
REQ-007 SHALL have port write_in, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port size_in, input, 2: 00 byte, 01 half, 10 word; 11 treated as word.
REQ-009 SHALL have ports paddr (output, 32), psel (output, 1), penable (output, 1), pwrite (output, 1), pwdata (output, 32), pstrb (output, 4): APB4 requester signals.
REQ-010 SHALL have ports prdata (input, 32), pready (input, 1), pslverr (input, 1): APB4 completer response.
REQ-011 SHALL have ports busy (output, 1), done (output, 1), rdata (output, 32), err (output, 1), err_code (output, 2): core-side status; err_code 00 none, 01 slverr, 10 timeout, 11 misaligned.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, ACCESS, FAULT.
REQ-013 IDLE with req=1: latch addr_in, wdata_in, write_in, size_in; go SETUP if aligned, else FAULT.
REQ-014 Misaligned means half with addr[0]=1, or word with addr[1:0]!=0; no psel asserted for a misaligned request.
REQ-015 SETUP: psel=1, penable=0, exactly one cycle, then ACCESS.
REQ-016 ACCESS: psel=1, penable=1; paddr, pwrite, pwdata, pstrb held stable from SETUP until exit.
REQ-017 paddr SHALL equal the latched address unmodified.
REQ-018 Writes: pwdata replicates the byte x4 (byte) or the halfword x2 (half), or passes the word unchanged; pstrb = 0001, 0011, or 1111 shifted left by addr[1:0].
REQ-019 Reads: pstrb SHALL be 0000.
REQ-020 ACCESS with pready=1: go IDLE; done=1 for one cycle on the next cycle; err=pslverr; err_code=01 if pslverr, else 00.
REQ-021 On a completed read, rdata SHALL be prdata shifted right by 8*addr[1:0], captured in the pready cycle, even when pslverr=1.
REQ-022 On a completed write, rdata SHALL be unchanged.
REQ-023 Wait-state counter: cleared on SETUP entry; increments each ACCESS cycle with pready=0.
REQ-024 Timeout: if pready=0 when the counter reaches TIMEOUT-1, go IDLE, drop psel/penable next cycle, pulse done with err=1 and err_code=10, leave rdata unchanged.
REQ-025 FAULT: one cycle, then IDLE; done=1 with err=1 and err_code=11 on the cycle after FAULT.
REQ-026 err and err_code SHALL hold until the next done pulse.
REQ-027 busy SHALL be 1 in SETUP, ACCESS and FAULT, and 0 in IDLE.
REQ-028 req asserted while busy=1 SHALL be ignored; the core re-presents it after done.
REQ-029 A req in the done cycle SHALL be accepted (state is IDLE); back-to-back transfers have a minimum 3-cycle period.
REQ-030 Zero-wait read latency: req at cycle 0 -> SETUP at 1, ACCESS at 2, done/rdata valid at 3.
REQ-031 psel, penable and pready/pslverr SHALL be ignored outside ACCESS.

Reset
REQ-032 rst=1 at an edge SHALL force IDLE and set psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, busy=0, done=0, err=0, err_code=00, rdata=0, counter=0.
REQ-033 Reset mid-transfer SHALL abort with no done pulse; psel=0 on the cycle after the reset edge.
REQ-034 rst SHALL take priority over pready and req in the same cycle.

Verification
REQ-035 Word read addr 0x100, completer returns 0xDEADBEEF with pready=1 in the first ACCESS cycle -> psel at cycle 1, penable at cycle 2, done at cycle 3, rdata=0xDEADBEEF, err=0.
REQ-036 Byte write addr 0x203, wdata 0x000000A5 -> pwdata=0xA5A5A5A5, pstrb=1000; half read addr 0x202 with prdata=0x12345678 -> rdata=0x00001234.
REQ-037 Read with pready held low 3 cycles then pready=1 with pslverr=1 -> penable for 4 cycles, done with err=1, err_code=01, rdata captured.
REQ-038 TIMEOUT=4, pready stuck 0 -> ACCESS lasts 4 cycles, then psel=0, done with err_code=10; a new req is then accepted normally.
REQ-039 Word req at addr 0x102 -> psel never asserted, done 2 cycles after req, err_code=11.
REQ-040 rst asserted during ACCESS -> next cycle psel=0, busy=0, no done pulse; a req issued while busy is ignored (no second transfer).
